decoder_nm_seq: RTL and testbench

DECODER_NM_SEQ -- requirements
Module: decoder_nm_seq

---
 rtl/decoder_nm_seq.sv | 129 ++++++++++++
 tb/tb_decoder_nm_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nm_seq.sv
// N-to-2^N decoder with a direct (sel-driven) mode and an auto-scan mode
// that walks the one-hot output with a programmable dwell per position.
module decoder_nm_seq #(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [N-1:0]         sel,
  input  logic                 sel_valid,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(1<<N)-1:0]    y,
  output logic                 y_valid,
  output logic [N-1:0]         idx,
  output logic                 wrap
);

  localparam int W = 1 << N;
  localparam logic [W-1:0]       Y_ONE   = W'(1'b1);
  localparam logic [N-1:0]       IDX_ONE = N'(1'b1);
  localparam logic [N-1:0]       IDX_MAX = {N{1'b1}};
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [W-1:0]       y_r, y_s;
  logic               y_valid_r, y_valid_s;
  logic [N-1:0]       idx_r, idx_s;
  logic               wrap_r, wrap_s;
  logic [DWELL_W-1:0] cnt_r, cnt_s;

  // Next-state and next-output logic; en low overrides everything.
  always_comb begin
    state_s   = state_r;
    y_s       = y_r;
    y_valid_s = y_valid_r;
    idx_s     = idx_r;
    wrap_s    = 1'b0;
    cnt_s     = cnt_r;
    if (!en) begin
      state_s   = IDLE;
      y_s       = '0;
      y_valid_s = 1'b0;
      idx_s     = '0;
      cnt_s     = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mode) begin
            state_s   = SCAN;
            idx_s     = '0;
            y_s       = Y_ONE;
            y_valid_s = 1'b1;
            cnt_s     = dwell;
          end else begin
            state_s   = DIRECT;
          end
        end
        DIRECT: begin
          if (mode) begin
            state_s   = SCAN;
            idx_s     = '0;
            y_s       = Y_ONE;
            y_valid_s = 1'b1;
            cnt_s     = dwell;
          end else if (sel_valid) begin
            y_s       = Y_ONE << sel;
            idx_s     = sel;
            y_valid_s = 1'b1;
          end else begin
            state_s   = DIRECT;
          end
        end
        SCAN: begin
          // Leaving scan keeps the last scan outputs until a new select.
          if (!mode) begin
            state_s = DIRECT;
          end else if (cnt_r == '0) begin
            idx_s   = idx_r + IDX_ONE;
            y_s     = Y_ONE << idx_s;
            wrap_s  = (idx_r == IDX_MAX);
            cnt_s   = dwell;
          end else begin
            cnt_s   = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_s   = IDLE;
          y_s       = '0;
          y_valid_s = 1'b0;
          idx_s     = '0;
          cnt_s     = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      y_r       <= '0;
      y_valid_r <= 1'b0;
      idx_r     <= '0;
      wrap_r    <= 1'b0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_s;
      y_r       <= y_s;
      y_valid_r <= y_valid_s;
      idx_r     <= idx_s;
      wrap_r    <= wrap_s;
      cnt_r     <= cnt_s;
    end
  end

  assign y       = y_r;
  assign y_valid = y_valid_r;
  assign idx     = idx_r;
  assign wrap    = wrap_r;

endmodule

// File: tb/tb_decoder_nm_seq.sv
// Scoreboard bench for decoder_nm_seq: main checks at N=3, mode-toggle
// scenario also at N=1 and N=6 sharing the same stimulus.
module tb_decoder_nm_seq;

  typedef struct packed {
    logic [7:0] y;
    logic       v;
    logic [2:0] idx;
    logic       w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] sel;
  logic       sel_valid;
  logic [3:0] dwell;

  logic [7:0]  y;   logic y_valid;  logic [2:0] idx; logic wrap;
  logic [1:0]  y1;  logic y_valid1; logic       idx1; logic wrap1;
  logic [63:0] y6;  logic y_valid6; logic [5:0] idx6; logic wrap6;
  logic        sel1;
  logic [5:0]  sel6;

  exp_t sb[$];
  exp_t e;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  assign sel1 = sel[0];
  assign sel6 = {3'b000, sel};

  always #5 clk = ~clk;

  decoder_nm_seq #(.N(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .sel_valid(sel_valid), .dwell(dwell),
    .y(y), .y_valid(y_valid), .idx(idx), .wrap(wrap));

  decoder_nm_seq #(.N(1), .DWELL_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel1),
    .sel_valid(sel_valid), .dwell(dwell),
    .y(y1), .y_valid(y_valid1), .idx(idx1), .wrap(wrap1));

  decoder_nm_seq #(.N(6), .DWELL_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel6),
    .sel_valid(sel_valid), .dwell(dwell),
    .y(y6), .y_valid(y_valid6), .idx(idx6), .wrap(wrap6));

  function automatic exp_t scan_exp(int t, int d);
    exp_t r;
    int k;
    k     = t / (d + 1);
    r.idx = 3'(k % 8);
    r.y   = 8'h01 << r.idx;
    r.v   = 1'b1;
    r.w   = (t > 0) && (t % (d + 1) == 0) && (k % 8 == 0);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 3'd0; sel_valid = 1'b0; dwell = 4'd0;
    #2;
    sb.push_back('{y: 8'h00, v: 1'b0, idx: 3'd0, w: 1'b0});
    e = sb.pop_front(); total_cnt++;
    if ({y, y_valid, idx, wrap} !== e)
      $display("FAIL reset got y=%h v=%b idx=%0d wrap=%b exp y=%h v=%b idx=%0d wrap=%b",
               y, y_valid, idx, wrap, e.y, e.v, e.idx, e.w);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back('{y: 8'h00, v: 1'b0, idx: 3'd0, w: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front(); total_cnt++;
    if ({y, y_valid, idx, wrap} !== e)
      $display("FAIL reset_idle got y=%h v=%b idx=%0d wrap=%b exp y=%h v=%b idx=%0d wrap=%b",
               y, y_valid, idx, wrap, e.y, e.v, e.idx, e.w);
    else pass_cnt++;
  endtask

  task automatic test_direct_sweep();
    for (int t = 0; t < 12; t++) begin
      en = 1'b1; mode = 1'b0;
      if (t == 0) begin
        sel_valid = 1'b1; sel = 3'd4;
        sb.push_back('{y: 8'h00, v: 1'b0, idx: 3'd0, w: 1'b0});
      end else if (t == 1) begin
        sel_valid = 1'b0; sel = 3'd4;
        sb.push_back('{y: 8'h00, v: 1'b0, idx: 3'd0, w: 1'b0});
      end else if (t < 10) begin
        sel_valid = 1'b1; sel = 3'(t - 2);
        sb.push_back('{y: 8'h01 << (t - 2), v: 1'b1, idx: 3'(t - 2), w: 1'b0});
      end else begin
        sel_valid = 1'b0; sel = 3'd2;
        sb.push_back('{y: 8'h80, v: 1'b1, idx: 3'd7, w: 1'b0});
      end
      @(posedge clk); #1;
      e = sb.pop_front(); total_cnt++;
      if ({y, y_valid, idx, wrap} !== e)
        $display("FAIL direct_sweep t=%0d got y=%h v=%b idx=%0d wrap=%b exp y=%h v=%b idx=%0d wrap=%b",
                 t, y, y_valid, idx, wrap, e.y, e.v, e.idx, e.w);
      else pass_cnt++;
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_scan(int d, int cycles);
    for (int t = -1; t < cycles; t++) begin
      if (t < 0) begin
        en = 1'b0;
        sb.push_back('{y: 8'h00, v: 1'b0, idx: 3'd0, w: 1'b0});
      end else begin
        en = 1'b1; mode = 1'b1; dwell = 4'(d);
        sel_valid = t[0]; sel = 3'(t);
        sb.push_back(scan_exp(t, d));
      end
      @(posedge clk); #1;
      e = sb.pop_front(); total_cnt++;
      if ({y, y_valid, idx, wrap} !== e)
        $display("FAIL scan_dwell%0d t=%0d got y=%h v=%b idx=%0d wrap=%b exp y=%h v=%b idx=%0d wrap=%b",
                 d, t, y, y_valid, idx, wrap, e.y, e.v, e.idx, e.w);
      else pass_cnt++;
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_en_priority();
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin
        en = 1'b0;
        sb.push_back('{y: 8'h00, v: 1'b0, idx: 3'd0, w: 1'b0});
      end else if (t == 1) begin
        en = 1'b1; mode = 1'b0; sel_valid = 1'b0;
        sb.push_back('{y: 8'h00, v: 1'b0, idx: 3'd0, w: 1'b0});
      end else if (t == 2) begin
        sel_valid = 1'b1; sel = 3'd5;
        sb.push_back('{y: 8'h20, v: 1'b1, idx: 3'd5, w: 1'b0});
      end else begin
        en = 1'b0; sel_valid = 1'b1; sel = 3'd3;
        sb.push_back('{y: 8'h00, v: 1'b0, idx: 3'd0, w: 1'b0});
      end
      @(posedge clk); #1;
      e = sb.pop_front(); total_cnt++;
      if ({y, y_valid, idx, wrap} !== e)
        $display("FAIL en_priority t=%0d got y=%h v=%b idx=%0d wrap=%b exp y=%h v=%b idx=%0d wrap=%b",
                 t, y, y_valid, idx, wrap, e.y, e.v, e.idx, e.w);
      else pass_cnt++;
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_dwell_change();
    int idx_tab[9] = '{0, 0, 0, 0, 1, 1, 2, 2, 3};
    exp_t x;
    for (int t = 0; t < 9; t++) begin
      en = 1'b1; mode = 1'b1;
      dwell = (t == 0) ? 4'd3 : 4'd1;
      x.idx = 3'(idx_tab[t]);
      x.y   = 8'h01 << x.idx;
      x.v   = 1'b1;
      x.w   = 1'b0;
      sb.push_back(x);
      @(posedge clk); #1;
      e = sb.pop_front(); total_cnt++;
      if ({y, y_valid, idx, wrap} !== e)
        $display("FAIL dwell_change t=%0d got y=%h v=%b idx=%0d wrap=%b exp y=%h v=%b idx=%0d wrap=%b",
                 t, y, y_valid, idx, wrap, e.y, e.v, e.idx, e.w);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_scan();
    test_scan(0, 6);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back('{y: 8'h00, v: 1'b0, idx: 3'd0, w: 1'b0});
    e = sb.pop_front(); total_cnt++;
    if ({y, y_valid, idx, wrap} !== e)
      $display("FAIL reset_mid_scan got y=%h v=%b idx=%0d wrap=%b exp y=%h v=%b idx=%0d wrap=%b",
               y, y_valid, idx, wrap, e.y, e.v, e.idx, e.w);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back('{y: 8'h01, v: 1'b1, idx: 3'd0, w: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front(); total_cnt++;
    if ({y, y_valid, idx, wrap} !== e)
      $display("FAIL scan_restart got y=%h v=%b idx=%0d wrap=%b exp y=%h v=%b idx=%0d wrap=%b",
               y, y_valid, idx, wrap, e.y, e.v, e.idx, e.w);
    else pass_cnt++;
  endtask

  task automatic test_mode_toggle();
    logic [1:0]  e1y;
    logic        e1i;
    logic [63:0] e6y;
    logic [5:0]  e6i;
    test_scan(0, 4);
    for (int t = 0; t < 3; t++) begin
      mode = 1'b0;
      sel_valid = (t == 2);
      sel = (t == 2) ? 3'd6 : 3'd1;
      if (t < 2) begin
        sb.push_back('{y: 8'h08, v: 1'b1, idx: 3'd3, w: 1'b0});
        e1y = 2'b10; e1i = 1'b1; e6y = 64'd1 << 3; e6i = 6'd3;
      end else begin
        sb.push_back('{y: 8'h40, v: 1'b1, idx: 3'd6, w: 1'b0});
        e1y = 2'b01; e1i = 1'b0; e6y = 64'd1 << 6; e6i = 6'd6;
      end
      @(posedge clk); #1;
      e = sb.pop_front(); total_cnt++;
      if ({y, y_valid, idx, wrap} !== e)
        $display("FAIL mode_toggle_n3 t=%0d got y=%h v=%b idx=%0d wrap=%b exp y=%h v=%b idx=%0d wrap=%b",
                 t, y, y_valid, idx, wrap, e.y, e.v, e.idx, e.w);
      else pass_cnt++;
      total_cnt++;
      if ({y1, y_valid1, idx1, wrap1} !== {e1y, 1'b1, e1i, 1'b0})
        $display("FAIL mode_toggle_n1 t=%0d got y=%b v=%b idx=%0d wrap=%b exp y=%b v=1 idx=%0d wrap=0",
                 t, y1, y_valid1, idx1, wrap1, e1y, e1i);
      else pass_cnt++;
      total_cnt++;
      if ({y6, y_valid6, idx6, wrap6} !== {e6y, 1'b1, e6i, 1'b0})
        $display("FAIL mode_toggle_n6 t=%0d got y=%h v=%b idx=%0d wrap=%b exp y=%h v=1 idx=%0d wrap=0",
                 t, y6, y_valid6, idx6, wrap6, e6y, e6i);
      else pass_cnt++;
    end
    sel_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direct_sweep();
    test_scan(2, 27);
    test_scan(0, 18);
    test_en_priority();
    test_dwell_change();
    test_reset_mid_scan();
    test_mode_toggle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
